// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and types for the interrupt controller.
//   NSRC       - default number of interrupt sources (bit 0 = highest priority)
//   ID_W       - width of a source index
//   VEC_BASE   - handler address of source 0
//   VEC_STRIDE - address step between consecutive sources' handlers
//   irq_state_e - request FSM states (IDLE, REQ)
package irq_pkg;

   localparam int unsigned NSRC       = 3;
   localparam int unsigned ID_W       = $clog2(NSRC);
   localparam logic [31:0] VEC_BASE   = 32'h0000_3000;
   localparam logic [31:0] VEC_STRIDE = 32'h0000_0100;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } irq_state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: brings one asynchronous request line into the clk domain
// and flags its rising edges.
//   clk  - system clock
//   rst  - synchronous active-high reset; clears every flop, so an edge
//          still travelling through the synchroniser is dropped
//   raw  - asynchronous request level
//   rise - one-cycle pulse for each 0->1 transition of the synchronised level
module irq_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   logic s1;
   logic s2;
   logic h;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         h  <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         h  <= s2;
      end
   end

   // A level held high produces a single pulse: h catches up one cycle later.
   assign rise = s2 & ~h;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority, nesting interrupt controller.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   irq_raw    - asynchronous raw request levels, one per source
//   int_en     - global interrupt enable from the CPU
//   ack        - CPU takes the presented request (only honoured while int_req=1)
//   eret       - one-cycle pulse on return from the current handler
//   int_req    - registered request to the CPU
//   int_id     - index of the presented source
//   int_vec    - handler address of the presented source
//   pending    - latched requests not yet acknowledged
//   in_service - acknowledged sources not yet returned from
module irq_ctrl #(
   parameter int unsigned NSRC       = irq_pkg::NSRC,
   parameter logic [31:0] VEC_BASE   = irq_pkg::VEC_BASE,
   parameter logic [31:0] VEC_STRIDE = irq_pkg::VEC_STRIDE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NSRC-1:0]         irq_raw,
   input  logic                    int_en,
   input  logic                    ack,
   input  logic                    eret,
   output logic                    int_req,
   output logic [$clog2(NSRC)-1:0] int_id,
   output logic [31:0]             int_vec,
   output logic [NSRC-1:0]         pending,
   output logic [NSRC-1:0]         in_service
);

   import irq_pkg::*;

   localparam int unsigned SEL_W = $clog2(NSRC);

   // Pending sources whose priority beats every in-service source.
   function automatic logic [NSRC-1:0] eligible_mask(input logic [NSRC-1:0] pend,
                                                     input logic [NSRC-1:0] isv);
      logic [NSRC-1:0] m;
      logic            blocked;
      m       = '0;
      blocked = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (isv[i]) blocked = 1'b1;
         if (!blocked) m[i] = pend[i];
      end
      return m;
   endfunction

   // Index of the highest-priority (lowest-numbered) set bit.
   function automatic logic [SEL_W-1:0] first_idx(input logic [NSRC-1:0] v);
      logic [SEL_W-1:0] idx;
      logic             found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (v[i] && !found) begin
            idx   = SEL_W'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   // Highest-priority set bit isolated as a one-hot mask (zero if v is zero).
   function automatic logic [NSRC-1:0] first_onehot(input logic [NSRC-1:0] v);
      return v & (~v + NSRC'(1));
   endfunction

   irq_state_e       state;
   irq_state_e       state_nxt;
   logic [SEL_W-1:0] id_nxt;
   logic [31:0]      vec_nxt;
   logic [NSRC-1:0]  pend_nxt;
   logic [NSRC-1:0]  isv_nxt;
   logic [NSRC-1:0]  rise;
   logic [NSRC-1:0]  elig;
   logic [NSRC-1:0]  id_onehot;
   logic             take;

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      irq_edge_sync u_sync (
         .clk  (clk),
         .rst  (rst),
         .raw  (irq_raw[g]),
         .rise (rise[g])
      );
   end

   assign int_req   = (state == REQ);
   assign elig      = eligible_mask(pending, in_service);
   assign id_onehot = NSRC'(1) << int_id;
   // ack outside a presented request is meaningless and ignored.
   assign take      = ack && (state == REQ);

   always_comb begin
      state_nxt = state;
      id_nxt    = int_id;
      vec_nxt   = int_vec;

      // eret retires the innermost handler before ack adds the new one,
      // so a same-cycle ack/eret swaps service levels cleanly.
      isv_nxt = in_service & ~first_onehot(in_service);
      if (!eret) isv_nxt = in_service;
      if (take)  isv_nxt = isv_nxt | id_onehot;

      // A new edge on the acknowledged source survives the ack clear.
      pend_nxt = pending;
      if (take) pend_nxt = pend_nxt & ~id_onehot;
      pend_nxt = pend_nxt | rise;

      unique case (state)
         IDLE: begin
            if (int_en && (elig != '0)) begin
               state_nxt = REQ;
               id_nxt    = first_idx(elig);
            end
         end
         REQ: begin
            if (take || !int_en || (elig == '0)) begin
               state_nxt = IDLE;
            end else begin
               id_nxt = first_idx(elig);
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (id_nxt != int_id || state_nxt == REQ) begin
         vec_nxt = VEC_BASE + 32'(id_nxt) * VEC_STRIDE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         int_id     <= '0;
         int_vec    <= '0;
         pending    <= '0;
         in_service <= '0;
      end else begin
         state      <= state_nxt;
         int_id     <= id_nxt;
         int_vec    <= vec_nxt;
         pending    <= pend_nxt;
         in_service <= isv_nxt;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus random traffic for irq_ctrl, every
// cycle compared against a cycle-level reference model of the controller.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  irq_raw;
   logic        int_en;
   logic        ack;
   logic        eret;
   logic        int_req;
   logic [1:0]  int_id;
   logic [31:0] int_vec;
   logic [2:0]  pending;
   logic [2:0]  in_service;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference model state
   logic        m_req;
   int unsigned m_id;
   logic [2:0]  m_pend;
   logic [2:0]  m_isv;
   logic [2:0]  hist1, hist2, hist3;  // raw samples 1, 2, 3 edges ago

   irq_ctrl #(
      .NSRC       (3),
      .VEC_BASE   (32'h0000_3000),
      .VEC_STRIDE (32'h0000_0100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_raw    (irq_raw),
      .int_en     (int_en),
      .ack        (ack),
      .eret       (eret),
      .int_req    (int_req),
      .int_id     (int_id),
      .int_vec    (int_vec),
      .pending    (pending),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned lowest(input logic [2:0] v);
      for (int i = 0; i < 3; i++) if (v[i]) return i;
      return 3;
   endfunction

   task automatic model_update();
      logic [2:0]  rise;
      logic [2:0]  elig;
      logic [2:0]  isv;
      logic [2:0]  pend;
      logic        take;
      int unsigned ceil;
      if (rst) begin
         m_req = 1'b0; m_id = 0; m_pend = '0; m_isv = '0;
         hist1 = '0; hist2 = '0; hist3 = '0;
      end else begin
         // raw seen high two edges ago but low three edges ago
         rise = hist2 & ~hist3;
         take = ack && m_req;
         ceil = lowest(m_isv);
         elig = '0;
         for (int i = 0; i < 3; i++) if (i < ceil) elig[i] = m_pend[i];
         isv = m_isv;
         if (eret && isv != 0) isv[lowest(isv)] = 1'b0;
         if (take) isv[m_id] = 1'b1;
         pend = m_pend;
         if (take) pend[m_id] = 1'b0;
         pend = pend | rise;
         if (!m_req) begin
            if (int_en && elig != 0) begin m_req = 1'b1; m_id = lowest(elig); end
         end else if (take || !int_en || elig == 0) begin
            m_req = 1'b0;
         end else begin
            m_id = lowest(elig);
         end
         m_pend = pend;
         m_isv  = isv;
         hist3 = hist2; hist2 = hist1; hist1 = irq_raw;
      end
   endtask

   task automatic compare_all();
      check("int_req", 32'(int_req), 32'(m_req));
      check("pending", 32'(pending), 32'(m_pend));
      check("in_service", 32'(in_service), 32'(m_isv));
      if (m_req) begin
         check("int_id", 32'(int_id), m_id);
         check("int_vec", int_vec, 32'h0000_3000 + m_id * 32'h0000_0100);
      end
      if (rst) begin
         check("rst_id", 32'(int_id), 32'h0);
         check("rst_vec", int_vec, 32'h0);
      end
   endtask

   task automatic step(input logic r, input logic [2:0] raw, input logic en,
                       input logic a, input logic e);
      rst = r; irq_raw = raw; int_en = en; ack = a; eret = e;
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [2:0] raw_r;

      // reset with all lines high, then edges become visible after release
      step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
      check("rst_req", 32'(int_req), 32'h0);
      check("rst_pend", 32'(pending), 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
      check("post_rst_pend", 32'(pending), 32'h7);

      // single source
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
      check("single_req", 32'(int_req), 32'h1);
      check("single_vec", int_vec, 32'h0000_3200);
      step(1'b0, 3'b100, 1'b1, 1'b1, 1'b0);
      check("single_pend", 32'(pending), 32'h0);
      check("single_isv", 32'(in_service), 32'h4);

      // nesting on top of source 2
      for (int i = 0; i < 4; i++) step(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
      check("nest_id", 32'(int_id), 32'h0);
      check("nest_vec", int_vec, 32'h0000_3000);
      step(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
      check("nest_isv", 32'(in_service), 32'h5);
      step(1'b0, 3'b101, 1'b1, 1'b0, 1'b1);
      check("nest_eret1", 32'(in_service), 32'h4);
      step(1'b0, 3'b101, 1'b1, 1'b0, 1'b1);
      check("nest_eret2", 32'(in_service), 32'h0);

      // priority block: source 1 waits behind source 0 in service
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b001, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 3'b011, 1'b1, 1'b0, 1'b0);
      check("blk_pend", 32'(pending), 32'h2);
      check("blk_req", 32'(int_req), 32'h0);
      step(1'b0, 3'b011, 1'b1, 1'b0, 1'b1);
      step(1'b0, 3'b011, 1'b1, 1'b0, 1'b0);
      check("blk_after_req", 32'(int_req), 32'h1);
      check("blk_after_id", 32'(int_id), 32'h1);

      // ack and eret together: in_service 010, presenting id 0
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b010, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 3'b011, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b011, 1'b1, 1'b1, 1'b1);
      check("ackeret_isv", 32'(in_service), 32'h1);

      // ack coinciding with a new edge on the same source
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b100, 1'b1, 1'b1, 1'b0);
      check("ackedge_pend", 32'(pending), 32'h4);

      // gating by int_en
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      check("gate_req", 32'(int_req), 32'h0);
      check("gate_pend", 32'(pending), 32'h1);
      step(1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
      check("gate_open_req", 32'(int_req), 32'h1);

      // level held high: one event only
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      check("held_pend", 32'(pending), 32'h2);
      step(1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b010, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
      check("held_pend_after", 32'(pending), 32'h0);

      // random traffic
      do_reset();
      raw_r = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(7) == 0) raw_r[b] = ~raw_r[b];
         step(($urandom_range(499) == 0),
              raw_r,
              ($urandom_range(7) != 0),
              (m_req && $urandom_range(1) == 1),
              ($urandom_range(4) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
